// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the default datapath width.
package alu_pkg;

  localparam int unsigned W_DEFAULT = 32;

  // Opcode class carried in f[2:1]; f[0] substitutes operand b with 1.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } alu_state_e;

  // Value loaded into the execute down-counter: latency minus one.
  function automatic logic [3:0] lat_m1(input logic [2:0] f, input int unsigned mul_lat);
    return (f[2:1] == OP_MUL) ? 4'(mul_lat - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational add/sub/mul datapath; f[0] turns operand b into 1 so the
// same opcodes give increment/decrement/identity-multiply.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   f,
  output logic [W-1:0] r,
  output logic         err
);

  logic [W-1:0] b_eff;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;

  // Operand selection: low halves only feed the multiplier.
  always_comb begin
    b_eff = f[0] ? W'(1) : b;
    mul_a = {{(W - 16){1'b0}}, a[15:0]};
    mul_b = {{(W - 16){1'b0}}, b_eff[15:0]};
  end

  // Result mux; illegal opcode yields zero with the error flag set.
  always_comb begin
    r   = '0;
    err = 1'b0;
    unique case (f[2:1])
      OP_ADD: r = a + b_eff;
      OP_SUB: r = a - b_eff;
      OP_MUL: r = mul_a * mul_b;
      OP_ILL: err = 1'b1;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU. One operation
// is in flight at a time: IDLE grants and latches, EXEC waits out the op
// latency, RESP holds the registered result until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W       = W_DEFAULT,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic [1:0]     i_req_valid,
  output logic [1:0]     o_req_ready,
  input  logic [2*W-1:0] i_req_a,
  input  logic [2*W-1:0] i_req_b,
  input  logic [5:0]     i_req_f,
  output logic           o_rsp_valid,
  input  logic           i_rsp_ready,
  output logic           o_rsp_id,
  output logic [W-1:0]   o_rsp_data,
  output logic           o_rsp_err
);

  alu_state_e   state_q;
  logic [3:0]   cnt_q;
  logic         rr_q;       // id of the last requester served
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   f_q;
  logic         id_q;

  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_data_q;
  logic         rsp_err_q;

  logic [1:0]   grant;
  logic         accept;
  logic         win_id;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [2:0]   sel_f;
  logic [W-1:0] core_r;
  logic         core_err;

  // Round-robin grant: the requester served last loses a tie.
  always_comb begin
    grant = 2'b00;
    if (state_q == StIdle && i_reset_n) begin
      unique case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign o_req_ready = grant;
  assign accept      = |(i_req_valid & grant);
  assign win_id      = grant[1];
  assign sel_a       = win_id ? i_req_a[2*W-1:W] : i_req_a[W-1:0];
  assign sel_b       = win_id ? i_req_b[2*W-1:W] : i_req_b[W-1:0];
  assign sel_f       = win_id ? i_req_f[5:3] : i_req_f[2:0];

  alu_core #(
    .W(W)
  ) u_core (
    .a  (a_q),
    .b  (b_q),
    .f  (f_q),
    .r  (core_r),
    .err(core_err)
  );

  // Control FSM with registered response outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rr_q        <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= 3'd0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            f_q     <= sel_f;
            id_q    <= win_id;
            cnt_q   <= lat_m1(sel_f, MUL_LAT);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q  <= core_r;
            rsp_err_q   <= core_err;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            rr_q        <= rsp_id_q;
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push an expected
// response (value, id, arrival cycle); a response monitor pops and compares.
module tb_alu_arbiter;

  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_f;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  alu_arbiter #(
    .W      (32),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_a    (req_a),
    .i_req_b    (req_b),
    .i_req_f    (req_f),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_id   (rsp_id),
    .o_rsp_data (rsp_data),
    .o_rsp_err  (rsp_err)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  logic acc_ids[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic last_id = 1'b1;
  logic head_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: {err, result} from the opcode rules.
  function automatic logic [32:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] bb;
    bb = f[0] ? 32'd1 : b;
    case (f[2:1])
      2'd0:    return {1'b0, a + bb};
      2'd1:    return {1'b0, a - bb};
      2'd2:    return {1'b0, (a % 32'd65536) * (bb % 32'd65536)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Accept observer: checks the grant and pushes expected responses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        sb.delete();
        last_id = 1'b1;
      end else begin
        logic [1:0] exp_rdy;
        exp_rdy = (sb.size() == 0) ? model_grant(req_valid, last_id) : 2'b00;
        chk("req_ready", req_ready, exp_rdy);
        if (|(exp_rdy & req_valid)) begin
          exp_t        e;
          logic        id;
          logic [2:0]  f;
          logic [32:0] r;
          id = exp_rdy[1];
          f  = id ? req_f[5:3] : req_f[2:0];
          r  = ref_op(f, id ? req_a[63:32] : req_a[31:0], id ? req_b[63:32] : req_b[31:0]);
          e.id      = id;
          e.data    = r[31:0];
          e.err     = r[32];
          e.exp_cyc = cyc + 1 + ((f[2:1] == 2'd2) ? int'(MUL_LAT) : 1);
          sb.push_back(e);
          acc_ids.push_back(id);
          last_id = id;
        end
      end
    end
  end

  // Response monitor: latency, hold-stability and content of each response.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        head_seen = 1'b0;
      end else if (sb.size() == 0) begin
        chk("no_rsp_expected", rsp_valid, 1'b0);
      end else if (rsp_valid) begin
        if (!head_seen) begin
          chk("rsp_cycle", cyc, sb[0].exp_cyc);
          head_seen = 1'b1;
        end
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_err", rsp_err, sb[0].err);
        if (rsp_ready) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end else if (cyc > sb[0].exp_cyc) begin
        chk("rsp_late", rsp_valid, 1'b1);
        void'(sb.pop_front());
        head_seen = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    req_f[id*3 +: 3]   = f;
    req_valid[id]      = 1'b1;
  endtask

  // Waits (bounded) for requester id to be accepted; returns just after that edge.
  task automatic wait_grant(input int id);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id] && req_valid[id]) got = 1'b1;
    end
    chk("grant_timeout", got, 1'b1);
    tick(1);
  endtask

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f);
    set_req(id, a, b, f);
    wait_grant(id);
    req_valid[id] = 1'b0;
    tick(MUL_LAT + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_f     = '0;
    rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Both requesters continuously valid: grants must alternate from 0.
    acc_ids.delete();
    set_req(0, 32'd1, 32'd2, 3'b000);
    set_req(1, 32'd10, 32'd20, 3'b000);
    tick(13);
    req_valid = 2'b00;
    tick(4);
    chk("alt_count", acc_ids.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < acc_ids.size(); i++) chk("alt_grant", acc_ids[i], i % 2);

    // Directed arithmetic cases.
    do_op(0, 32'd5, 32'd7, 3'b000);
    do_op(1, 32'h0001_0003, 32'h0000_0004, 3'b100);
    do_op(0, 32'd0, 32'd1, 3'b010);
    do_op(1, 32'd10, 32'd0, 3'b011);
    do_op(0, 32'h1234_5678, 32'd9, 3'b110);
    do_op(1, 32'hFFFF_FFFF, 32'd0, 3'b001);

    // Consumer stall: response held, other requester kept waiting.
    rsp_ready = 1'b0;
    set_req(0, 32'd100, 32'd23, 3'b000);
    wait_grant(0);
    req_valid[0] = 1'b0;
    set_req(1, 32'd3, 32'd4, 3'b100);
    tick(7);
    rsp_ready = 1'b1;
    tick(6);
    req_valid = 2'b00;
    tick(3);

    // Reset during a multiply: no response, and requester 0 wins next.
    set_req(0, 32'd7, 32'd9, 3'b100);
    wait_grant(0);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    acc_ids.delete();
    set_req(0, 32'd1, 32'd1, 3'b000);
    set_req(1, 32'd2, 32'd2, 3'b000);
    tick(2);
    chk("post_reset_grant_seen", acc_ids.size() >= 1, 1'b1);
    if (acc_ids.size() >= 1) chk("post_reset_grant", acc_ids[0], 1'b0);
    req_valid = 2'b00;
    tick(5);

    // Randomized traffic with changing operands and consumer back-pressure.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) req_valid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        req_a[r*32 +: 32] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
        req_b[r*32 +: 32] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 20));
        req_f[r*3 +: 3]   = 3'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick(20);
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
